load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU: takes ALU result as effective address and busB as
//  store data, runs a req/gnt/rvalid handshake to data memory, and returns aligned, extended load data.
//  Stalls the single-cycle core while an access is outstanding; pure ALU instructions pass with no stall.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+WAIT before the access is abandoned with bus_err (1..65535)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  op_valid      in   1   current instruction is a memory op; held stable while stall=1
//  op_store      in   1   1=store, 0=load
//  op_size       in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  op_unsigned   in   1   loads: 1=zero-extend, 0=sign-extend
//  addr          in   32  effective address (ALUout)
//  wdata         in   32  store data (busB), right-justified
//  stall         out  1   freeze PC/regfile write
//  done          out  1   one-cycle pulse: access complete, rdata/bus_err valid
//  rdata         out  32  load result, extended
//  bus_err       out  1   valid with done: timeout (or misalign, see CONFIGURATION)
//  mem_req       out  1   request, held until mem_gnt
//  mem_we        out  1   write enable, stable with mem_req
//  mem_addr      out  32  word address, addr[1:0] forced 00
//  mem_be        out  4   byte enables, be[3]=bits 31:24 (big-endian, byte 0 = MSB)
//  mem_wdata     out  32  store data replicated into target lanes
//  mem_gnt       in   1   request accepted this cycle
//  mem_rvalid    in   1   load data valid this cycle
//  mem_rdata     in   32  load data
// BEHAVIOUR
//  Reset: state IDLE; stall, done, mem_req, mem_we, bus_err = 0; rdata, mem_addr, mem_be, mem_wdata = 0.
//  States: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//  IDLE: op_valid=1 -> capture op/addr/wdata, go REQ; stall=op_valid (combinational).
//  REQ: mem_req=1, stall=1, registered request fields. gnt & store -> DONE. gnt & load & rvalid
//       same cycle -> DONE with data. gnt & load -> WAIT.
//  WAIT: stall=1; rvalid -> capture data, DONE.
//  DONE: done=1, stall=0 for exactly one cycle; op_valid still high here but is NOT re-accepted; -> IDLE.
//  Min latency: store 3 cycles (accept, REQ+gnt, DONE); load 3 cycles if gnt & rvalid coincide, else 4+.
//  Lanes: byte k=addr[1:0] -> be=4'b1000>>k; half (addr[1]) -> be=1100 or 0011; word -> 1111.
//  Load extract: byte/half taken from selected lane, extended per op_unsigned to 32 bits.
//  Timeout: counter cleared on REQ entry, counts REQ+WAIT cycles; reaching TIMEOUT_CYCLES -> drop mem_req,
//   DONE with bus_err=1, rdata=0. Late rvalid after timeout is ignored.
//  mem_rvalid outside WAIT/REQ ignored. Reset mid-access: immediate IDLE, request dropped, no done.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no memory request;
//   IDLE -> DONE directly, bus_err=1, rdata=0 (2-cycle latency).
//  Not defined: low address bits ignored for alignment; half uses addr[1], word uses lane 0; never errors.
// STRUCTURE
//  lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, be_for(size,addr[1:0]) function.
//  Sub-module lsu_load_align: combinational lane select + sign/zero extension, instanced once.
// TESTING
//  LW addr 0x100, gnt cycle 1, rvalid=0xDEADBEEF cycle 2 -> done cycle 3, rdata=0xDEADBEEF, stall 1,1,1,0.
//  LB addr 0x103, rdata=0x000000F0 -> rdata=0xFFFFFFF0; LBU same -> 0x000000F0; mem_be=0001.
//  SH addr 0x102, wdata=0x1234 -> mem_be=0011, mem_wdata[15:0]=0x1234, mem_addr=0x100, mem_we=1, done after gnt.
//  LW with gnt held low, TIMEOUT_CYCLES=4 -> mem_req drops, done with bus_err=1, rdata=0; later rvalid ignored.
//  rst_n low while in WAIT -> all outputs 0 immediately; after release no done pulse, next op proceeds normally.
//  LW addr 0x102: with LSU_MISALIGN_TRAP_EN -> no mem_req, bus_err=1; without -> mem_addr=0x100, be=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : op_size encodings (2'b11 is reserved and treated as word)
//   lsuStateT               : access state machine encoding
//   opCtrlT                 : access attributes captured when an op is accepted
//   be_for()                : byte enables for a size and low address bits
//   replicateLanes()        : spreads right-justified store data across the byte lanes
//   isMisaligned()          : alignment test used when LSU_MISALIGN_TRAP_EN is defined
// Byte lanes are big-endian: byte 0 of a word is bits 31:24 and maps to be[3].
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsuStateT;

  typedef struct packed {
    logic       isStore;
    logic [1:0] size;
    logic       isUnsigned;
    logic [1:0] lane;
  } opCtrlT;

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: be_for = 4'b1000 >> lane;
      // Half accesses are selected by lane[1] only; lane[0] never moves the enables.
      SZ_HALF: be_for = lane[1] ? 4'b0011 : 4'b1100;
      default: be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicateLanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: replicateLanes = {4{data[7:0]}};
      SZ_HALF: replicateLanes = {2{data[15:0]}};
      default: replicateLanes = data;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: isMisaligned = 1'b0;
      SZ_HALF: isMisaligned = lane[0];
      default: isMisaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
//   mem_req    : request, held until mem_gnt
//   mem_we     : write enable, stable while mem_req is high
//   mem_addr   : word address, bits 1:0 always zero
//   mem_be     : byte enables, be[3] = bits 31:24
//   mem_wdata  : store data replicated into the target lanes
//   mem_gnt    : request accepted this cycle
//   mem_rvalid : load data valid this cycle
//   mem_rdata  : load data
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: picks the addressed byte or halfword out of
// the returned memory word and sign- or zero-extends it to 32 bits.
//   size       in  2   access size (SZ_BYTE/SZ_HALF, anything else = word)
//   lane       in  2   low address bits of the access
//   isUnsigned in  1   1 = zero-extend, 0 = sign-extend
//   wordIn     in  32  word as returned by memory
//   dataOut    out 32  aligned, extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        isUnsigned,
  input  logic [31:0] wordIn,
  output logic [31:0] dataOut
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // NOTE: every output of a combinational block gets a default before any branch,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    byteVal = wordIn[31:24];
    case (lane)
      2'd0: byteVal = wordIn[31:24];
      2'd1: byteVal = wordIn[23:16];
      2'd2: byteVal = wordIn[15:8];
      2'd3: byteVal = wordIn[7:0];
      default: byteVal = wordIn[31:24];
    endcase

    halfVal = lane[1] ? wordIn[15:0] : wordIn[31:16];

    dataOut = wordIn;
    case (size)
      SZ_BYTE: dataOut = isUnsigned ? {24'h0, byteVal} : {{24{byteVal[7]}}, byteVal};
      SZ_HALF: dataOut = isUnsigned ? {16'h0, halfVal} : {{16{halfVal[15]}}, halfVal};
      default: dataOut = wordIn;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage after the ALU. Uses the ALU result as effective address and busB as
// store data, runs a req/gnt/rvalid access on the data memory bus and returns
// aligned, extended load data. Holds the single-cycle core in stall while an
// access is outstanding; non-memory instructions pass without stalling.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before the access is abandoned
//                   with bus_err (1..65535)
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned half/word access issues no
//                         request and completes at once with bus_err=1.
//                         When undefined, low address bits are ignored for
//                         alignment and no access ever errors on alignment.
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   op_valid      current instruction is a memory op, held while stall=1
//   op_store      1 = store, 0 = load
//   op_size       00 byte, 01 half, 10 word, 11 treated as word
//   op_unsigned   loads: 1 = zero-extend, 0 = sign-extend
//   addr          effective address
//   wdata         right-justified store data
//   stall         freeze PC / register file write
//   done          one-cycle pulse, rdata and bus_err valid
//   rdata         extended load result
//   bus_err       timeout (or misalignment trap) indication, valid with done
//   mem           data memory bus, master side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_err,
  load_store_unit_if.master mem
);

  // Value of the cycle counter during the last REQ/WAIT cycle an access may use.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  lsuStateT    state;
  lsuStateT    nextState;
  opCtrlT      opReg;
  logic [15:0] cycleCnt;
  logic [31:0] rdataReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic [3:0]  beReg;
  logic        errReg;
  logic [31:0] alignedData;

  logic accept;
  logic misalignTrap;
  logic captureData;
  logic timedOut;
  logic reqActive;
  logic lastCycle;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalignTrap = isMisaligned(op_size, addr[1:0]);
`else
  assign misalignTrap = 1'b0;
`endif

  assign lastCycle = (cycleCnt == LAST_CNT);

  lsu_load_align u_load_align (
    .size      (opReg.size),
    .lane      (opReg.lane),
    .isUnsigned(opReg.isUnsigned),
    .wordIn    (mem.mem_rdata),
    .dataOut   (alignedData)
  );

  // Next-state and control decode. A successful completion in the final allowed
  // cycle wins over the timeout; a load granted in that cycle without data cannot
  // finish in time and is abandoned.
  always_comb begin
    nextState   = state;
    stall       = 1'b0;
    done        = 1'b0;
    reqActive   = 1'b0;
    accept      = 1'b0;
    captureData = 1'b0;
    timedOut    = 1'b0;

    case (state)
      IDLE: begin
        stall = op_valid;
        if (op_valid) begin
          accept    = 1'b1;
          nextState = misalignTrap ? DONE : REQ;
        end
      end

      REQ: begin
        stall     = 1'b1;
        reqActive = 1'b1;
        if (mem.mem_gnt && opReg.isStore) begin
          nextState = DONE;
        end else if (mem.mem_gnt && mem.mem_rvalid) begin
          captureData = 1'b1;
          nextState   = DONE;
        end else if (lastCycle) begin
          timedOut  = 1'b1;
          nextState = DONE;
        end else if (mem.mem_gnt) begin
          nextState = WAIT;
        end
      end

      WAIT: begin
        stall = 1'b1;
        if (mem.mem_rvalid) begin
          captureData = 1'b1;
          nextState   = DONE;
        end else if (lastCycle) begin
          timedOut  = 1'b1;
          nextState = DONE;
        end
      end

      // op_valid is still high here because the core only advances on this
      // edge; returning to IDLE unconditionally keeps it from being re-issued.
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end

      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: all registers here are control/datapath flops (no memory arrays), so
  // each one is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opReg    <= '0;
      cycleCnt <= '0;
      rdataReg <= '0;
      errReg   <= 1'b0;
      addrReg  <= '0;
      beReg    <= '0;
      wdataReg <= '0;
    end else begin
      state <= nextState;

      if (accept) begin
        opReg.isStore    <= op_store;
        opReg.size       <= op_size;
        opReg.isUnsigned <= op_unsigned;
        opReg.lane       <= addr[1:0];
        addrReg          <= {addr[31:2], 2'b00};
        beReg            <= be_for(op_size, addr[1:0]);
        wdataReg         <= replicateLanes(op_size, wdata);
        cycleCnt         <= '0;
        rdataReg         <= '0;
        errReg           <= misalignTrap;
      end else if (state == REQ || state == WAIT) begin
        cycleCnt <= cycleCnt + 16'd1;
      end

      if (captureData) begin
        rdataReg <= alignedData;
      end

      if (timedOut) begin
        rdataReg <= '0;
        errReg   <= 1'b1;
      end
    end
  end

  assign mem.mem_req   = reqActive;
  assign mem.mem_we    = reqActive & opReg.isStore;
  assign mem.mem_addr  = addrReg;
  assign mem.mem_be    = beReg;
  assign mem.mem_wdata = wdataReg;

  assign rdata   = rdataReg;
  assign bus_err = errReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. A reactive memory responder grants and
// returns data after chosen delays; expected results come from a byte-level model
// of the access (lane position, extension, cycle budget) evaluated per operation.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  load_store_unit_if memBus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_store   (op_store),
    .op_size    (op_size),
    .op_unsigned(op_unsigned),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .mem        (memBus)
  );

  logic [104:0] allOut;
  assign allOut = {stall, done, bus_err, memBus.mem_req, memBus.mem_we, memBus.mem_be,
                   rdata, memBus.mem_addr, memBus.mem_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] mask;
    logic [31:0] wlanes;
    logic [31:0] waddr;
    bit          trap;
  } expT;

  // Reference: an access covers nb bytes starting at byte 'first' of the
  // big-endian word; it completes c cycles after the request appears and must
  // do so within TO request/wait cycles.
  function automatic expT model(input bit st, input logic [1:0] sz, input bit uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int g, input int r, input logic [31:0] md);
    expT e;
    int nb, lane, first, sh, c;
    logic [31:0] low, raw;
    lane  = int'(a[1:0]);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    first = (lane / nb) * nb;
    sh    = 8 * (4 - first - nb);
    low   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    e.be  = 4'b0000;
    for (int b = first; b < first + nb; b++) e.be[3 - b] = 1'b1;
    e.mask   = low << sh;
    e.wlanes = (wd & low) << sh;
    e.waddr  = {a[31:2], 2'b00};
    raw      = (md >> sh) & low;
    if (!uns && nb < 4 && raw[8 * nb - 1]) raw = raw | ~low;
    e.trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e.trap = (lane % nb) != 0;
`endif
    c = st ? g : g + r;
    if (e.trap) begin
      e.lat = 1; e.err = 1'b1; e.rd = 32'h0;
    end else if (c >= TO) begin
      e.lat = TO + 1; e.err = 1'b1; e.rd = 32'h0;
    end else begin
      e.lat = c + 2; e.err = 1'b0; e.rd = raw;
    end
    return e;
  endfunction

  // Issues one op at a negedge with the DUT idle, answers the bus after g request
  // cycles (data r cycles after grant) and checks the result.
  task automatic do_op(input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int g, input int r, input logic [31:0] md,
                       input bit keepValid, input string tag);
    expT e;
    int  reqIdx, sinceGnt, doneAt;
    bit  gntGiven, stallBad;
    e = model(st, sz, uns, a, wd, g, r, md);
    op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = uns; addr = a; wdata = wd;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL %s accept_stall: got %b expected 1", tag, stall);
    end
    doneAt = -1; reqIdx = 0; sinceGnt = 0; gntGiven = 0; stallBad = 0;
    for (int k = 1; k <= 24 && doneAt < 0; k++) begin
      @(negedge clk);
      memBus.mem_gnt = 1'b0; memBus.mem_rvalid = 1'b0; memBus.mem_rdata = $urandom;
      if (done === 1'b1) begin
        doneAt = k;
      end else begin
        if (stall !== 1'b1) stallBad = 1;
        if (k == 1 && !e.trap) begin
          checks++;
          if ({memBus.mem_req, memBus.mem_we, memBus.mem_be, memBus.mem_addr} !==
              {1'b1, st, e.be, e.waddr}) begin
            errors++;
            $display("FAIL %s request: got req=%b we=%b be=%b addr=%h expected req=1 we=%b be=%b addr=%h",
                     tag, memBus.mem_req, memBus.mem_we, memBus.mem_be, memBus.mem_addr, st, e.be, e.waddr);
          end
          if (st) begin
            checks++;
            if ((memBus.mem_wdata & e.mask) !== e.wlanes) begin
              errors++;
              $display("FAIL %s store_lanes: got %h expected %h in mask %h",
                       tag, memBus.mem_wdata & e.mask, e.wlanes, e.mask);
            end
          end
        end
        if (!gntGiven) begin
          if (memBus.mem_req === 1'b1) begin
            if (reqIdx == g) begin
              memBus.mem_gnt = 1'b1; gntGiven = 1;
              if (!st && r == 0) begin memBus.mem_rvalid = 1'b1; memBus.mem_rdata = md; end
            end
            reqIdx++;
          end
        end else if (!st) begin
          sinceGnt++;
          if (sinceGnt == r) begin memBus.mem_rvalid = 1'b1; memBus.mem_rdata = md; end
        end
      end
    end
    checks++;
    if (doneAt != e.lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d cycles", tag, doneAt, e.lat);
    end
    if (doneAt > 0) begin
      checks++;
      if ({stall, bus_err, memBus.mem_req, stallBad} !== {1'b0, e.err, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s done_flags: got stall=%b err=%b req=%b stall_gap=%b expected stall=0 err=%b req=0 stall_gap=0",
                 tag, stall, bus_err, memBus.mem_req, stallBad, e.err);
      end
      if (!st || e.err) begin
        checks++;
        if (rdata !== e.rd) begin
          errors++; $display("FAIL %s rdata: got %h expected %h", tag, rdata, e.rd);
        end
      end
    end
    if (!keepValid) op_valid = 1'b0;
    @(negedge clk);
    memBus.mem_gnt = 1'b0; memBus.mem_rvalid = 1'b0;
    checks++;
    if ({done, memBus.mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_done: got done=%b req=%b expected 0 0", tag, done, memBus.mem_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op_store = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
    addr = '0; wdata = '0;
    memBus.mem_gnt = 1'b0; memBus.mem_rvalid = 1'b0; memBus.mem_rdata = '0;
    #12;
    checks++;
    if (allOut !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", allOut);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(0, 2'b10, 0, 32'h0000_0100, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, "lw_0x100");
    do_op(0, 2'b00, 0, 32'h0000_0103, 32'h0, 0, 0, 32'h0000_00F0, 0, "lb_0x103");
    do_op(0, 2'b00, 1, 32'h0000_0103, 32'h0, 0, 1, 32'h0000_00F0, 0, "lbu_0x103");
    do_op(1, 2'b01, 0, 32'h0000_0102, 32'h0000_1234, 1, 0, 32'h0, 0, "sh_0x102");
    do_op(0, 2'b01, 0, 32'h0000_0040, 32'h0, 2, 0, 32'h8001_7FFF, 0, "lh_upper");
    do_op(1, 2'b11, 0, 32'h0000_0044, 32'hA5A5_5A5A, 0, 0, 32'h0, 0, "sw_reserved_size");
  endtask

  task automatic test_timeout();
    do_op(0, 2'b10, 0, 32'h0000_0300, 32'h0, 20, 0, 32'h1111_2222, 0, "lw_timeout");
    for (int k = 0; k < 2; k++) begin
      memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'h7777_8888;
      @(negedge clk);
      checks++;
      if ({done, memBus.mem_req, rdata} !== {2'b00, 32'h0}) begin
        errors++;
        $display("FAIL late_rvalid: got done=%b req=%b rdata=%h expected 0 0 00000000",
                 done, memBus.mem_req, rdata);
      end
    end
    memBus.mem_rvalid = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    do_op(1, 2'b10, 0, 32'h0000_0400, 32'hCAFE_0001, TO - 1, 0, 32'h0, 0, "sw_last_cycle_gnt");
    do_op(1, 2'b10, 0, 32'h0000_0404, 32'hCAFE_0002, TO, 0, 32'h0, 0, "sw_gnt_too_late");
    do_op(0, 2'b10, 0, 32'h0000_0408, 32'h0, 1, TO - 2, 32'h1234_5678, 0, "lw_last_cycle_data");
    do_op(0, 2'b10, 0, 32'h0000_040C, 32'h0, 1, TO - 1, 32'h1234_5678, 0, "lw_data_too_late");
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'b10; op_unsigned = 1'b0;
    addr = 32'h0000_0200; wdata = '0;
    @(negedge clk);
    memBus.mem_gnt = 1'b1;
    @(negedge clk);
    memBus.mem_gnt = 1'b0;
    checks++;
    if ({stall, memBus.mem_req} !== 2'b10) begin
      errors++; $display("FAIL wait_state: got stall=%b req=%b expected 1 0", stall, memBus.mem_req);
    end
    #2; rst_n = 1'b0; op_valid = 1'b0;
    #1;
    checks++;
    if (allOut !== '0) begin
      errors++; $display("FAIL reset_in_wait: got %h expected 0", allOut);
    end
    @(negedge clk);
    rst_n = 1'b1; memBus.mem_rvalid = 1'b1; memBus.mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      memBus.mem_rvalid = 1'b0;
      checks++;
      if ({done, stall, memBus.mem_req} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_quiet: got done=%b stall=%b req=%b expected 0 0 0",
                 done, stall, memBus.mem_req);
      end
    end
    do_op(0, 2'b10, 0, 32'h0000_0204, 32'h0, 0, 0, 32'h0BAD_F00D, 0, "post_reset_lw");
  endtask

  task automatic test_misalign();
    do_op(0, 2'b10, 0, 32'h0000_0102, 32'h0, 0, 0, 32'h0102_0304, 0, "lw_0x102");
    do_op(1, 2'b01, 0, 32'h0000_0101, 32'h0000_BEEF, 0, 0, 32'h0, 0, "sh_0x101");
    do_op(0, 2'b01, 1, 32'h0000_0107, 32'h0, 0, 1, 32'h1234_ABCD, 0, "lhu_0x107");
  endtask

  task automatic test_back_to_back();
    do_op(0, 2'b00, 0, 32'h0000_0500, 32'h0, 0, 0, 32'h80FF_FFFF, 1, "b2b_lb");
    do_op(1, 2'b00, 0, 32'h0000_0502, 32'h0000_003C, 0, 0, 32'h0, 1, "b2b_sb");
    do_op(0, 2'b01, 0, 32'h0000_0506, 32'h0, 1, 1, 32'hFFFF_8001, 1, "b2b_lh");
    do_op(0, 2'b10, 0, 32'h0000_0508, 32'h0, 0, 2, 32'h0F0F_F0F0, 0, "b2b_lw");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 4), $urandom,
            bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
